// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer.
//   - default data / rotate-amount widths
//   - command op-codes carried on cmd_op
//   - FSM state encoding
package alu_seq_pkg;

  localparam int ALU_DATA_W  = 8;
  localparam int ALU_SHAMT_W = 3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ROL  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_rol_unit.sv
// Combinational rotate-left of a DATA_W word by shamt_i positions.
// The sequencer ties shamt_i to 1 for the iterative build, so synthesis
// reduces this to a single-step rotate; the barrel build feeds the full
// amount.
// Ports:
//   a_i      in   DATA_W   word to rotate
//   shamt_i  in   SHAMT_W  rotate amount (0 returns a_i unchanged)
//   y_o      out  DATA_W   rotated word
module alu_rol_unit #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
) (
  input  logic [DATA_W-1:0]  a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [DATA_W-1:0]  y_o
);

  // Output bit i takes input bit (i - shamt) mod DATA_W. The SHAMT_W-bit
  // subtraction wraps for free because DATA_W == 2**SHAMT_W, and no shift
  // by (DATA_W - shamt) is ever formed, so shamt == 0 needs no special case.
  always_comb begin
    y_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      y_o[i] = a_i[SHAMT_W'(i) - shamt_i];
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven controller for the shared add / rotate-left datapath.
// Holds accumulator A, accepts one command at a time on a valid/ready port
// and returns the new A on a valid/ready response port.
// Ports:
//   clk        in   1        clock
//   rst_n      in   1        asynchronous active-low reset
//   cmd_valid  in   1        command present
//   cmd_ready  out  1        high only in IDLE (registered)
//   cmd_op     in   2        00 LOAD, 01 ADD, 10 ROL, 11 READ
//   cmd_data   in   DATA_W   operand; ROL uses the low SHAMT_W bits
//   rsp_valid  out  1        result present, held until taken
//   rsp_ready  in   1        result consumed
//   rsp_data   out  DATA_W   value of A after the command
//   rsp_carry  out  1        ADD carry-out, 0 otherwise
//   busy       out  1        high in EXEC or RESP
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// EXEC    | iterative rotate, one bit per cycle, counter counts down
// RESP    | response held on rsp_* until rsp_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SHAMT_W = ALU_SHAMT_W,
  parameter int BARREL  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              busy
);

  state_e              state_q;
  logic [DATA_W-1:0]   a_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_carry_q;
  logic                busy_q;

  logic [SHAMT_W-1:0]  rol_k;
  logic [SHAMT_W-1:0]  rol_amt;
  logic [DATA_W-1:0]   rol_y;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   a_d;
  logic                carry_d;
  logic                go_exec;

  assign rol_k   = cmd_data[SHAMT_W-1:0];
  // Iterative build always steps by one; barrel build rotates the full amount
  // in the accept cycle and never enters EXEC.
  assign rol_amt = (BARREL != 0) ? rol_k : SHAMT_W'(1);

  alu_rol_unit #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_rol (
    .a_i     (a_q),
    .shamt_i (rol_amt),
    .y_o     (rol_y)
  );

  // Result of the command presented in IDLE, used only on accept.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, cmd_data};
    a_d     = a_q;
    carry_d = 1'b0;
    go_exec = 1'b0;
    case (cmd_op)
      OP_LOAD: a_d = cmd_data;
      OP_ADD:  {carry_d, a_d} = sum;
      OP_ROL: begin
        if (BARREL != 0) begin
          a_d = rol_y;
        end else if (rol_k != '0) begin
          go_exec = 1'b1;
        end
      end
      default: a_d = a_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // cmd_ready is held low through reset and rises one cycle after.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            a_q         <= a_d;
            if (go_exec) begin
              state_q <= ST_EXEC;
              cnt_q   <= rol_k;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= a_d;
              rsp_carry_q <= carry_d;
            end
          end
        end
        ST_EXEC: begin
          a_q   <= rol_y;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rol_y;
            rsp_carry_q <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance 0 is the iterative build, instance 1
// the barrel build. Expected values come from a plain-arithmetic model of A.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_carry, busy;
  logic [1:0] cmd_op   [2];
  logic [7:0] cmd_data [2];
  logic [7:0] rsp_data [2];

  int n_cmp = 0;
  int n_err = 0;
  int ref_a [2];

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(8), .SHAMT_W(3), .BARREL(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_carry(rsp_carry[0]),
    .busy(busy[0])
  );

  alu_op_sequencer #(.DATA_W(8), .SHAMT_W(3), .BARREL(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_carry(rsp_carry[1]),
    .busy(busy[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    n_cmp++;
    if (cmd_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_data[d] !== 8'h00 ||
        rsp_carry[d] !== 1'b0 || busy[d] !== 1'b0) begin
      n_err++;
      $display("FAIL %s dut%0d: got rdy=%b vld=%b data=%h carry=%b busy=%b expected all zero",
               tag, d, cmd_ready[d], rsp_valid[d], rsp_data[d], rsp_carry[d], busy[d]);
    end
  endtask

  // Issue one command, wait for its response, optionally stall rsp_ready for
  // 'hold' cycles (pulsing cmd_valid if poke), then consume it.
  task automatic do_cmd(input int d, input logic [1:0] op, input logic [7:0] data,
                        input int hold, input bit poke,
                        output logic [7:0] rd, output logic rc, output int lat);
    int ea, ec, el, k, guard;
    ea = ref_a[d]; ec = 0; el = 1;
    case (op)
      2'd0: ea = data;
      2'd1: begin
        ea = ref_a[d] + data;
        ec = (ea > 255) ? 1 : 0;
        ea = ea % 256;
      end
      2'd2: begin
        k = data % 8;
        for (int i = 0; i < k; i++) ea = ((ea * 2) % 256) + (ea / 128);
        el = (d == 1 || k == 0) ? 1 : 1 + k;
      end
      default: ea = ref_a[d];
    endcase
    rd = 8'hxx; rc = 1'bx; lat = 0;

    guard = 0;
    while (cmd_ready[d] !== 1'b1 && guard < 50) begin tick(); guard++; end
    n_cmp++;
    if (guard >= 50) begin
      n_err++;
      $display("FAIL cmd_ready_timeout dut%0d: got ready=%b expected 1 within 50 cycles", d, cmd_ready[d]);
      return;
    end
    cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_data[d] = data;
    tick();
    cmd_valid[d] = 1'b0;
    cmd_data[d]  = 8'($urandom);
    n_cmp++;
    if (cmd_ready[d] !== 1'b0) begin
      n_err++;
      $display("FAIL ready_after_accept dut%0d: got %b expected 0", d, cmd_ready[d]);
    end

    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 50) begin tick(); lat++; end
    n_cmp++;
    if (lat != el) begin
      n_err++;
      $display("FAIL latency dut%0d op%0d data %h: got %0d expected %0d", d, op, data, lat, el);
    end
    rd = rsp_data[d]; rc = rsp_carry[d];
    n_cmp++;
    if (rd !== 8'(ea) || rc !== 1'(ec) || busy[d] !== 1'b1) begin
      n_err++;
      $display("FAIL result dut%0d op%0d data %h: got %h c%b busy%b expected %h c%0d busy1",
               d, op, data, rd, rc, busy[d], 8'(ea), ec);
    end

    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        cmd_valid[d] = h[0]; cmd_op[d] = 2'd0; cmd_data[d] = 8'hFF;
      end
      tick();
      n_cmp++;
      if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== 8'(ea) || rsp_carry[d] !== 1'(ec) ||
          cmd_ready[d] !== 1'b0) begin
        n_err++;
        $display("FAIL stall dut%0d cycle %0d: got vld=%b data=%h c=%b rdy=%b expected 1 %h %0d 0",
                 d, h, rsp_valid[d], rsp_data[d], rsp_carry[d], cmd_ready[d], 8'(ea), ec);
      end
    end
    cmd_valid[d] = 1'b0;

    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
    n_cmp++;
    if (rsp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || cmd_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL after_consume dut%0d: got vld=%b busy=%b rdy=%b expected 0 0 1",
               d, rsp_valid[d], busy[d], cmd_ready[d]);
    end
    ref_a[d] = ea;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_outputs(0, "reset_values");
    check_reset_outputs(1, "reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    ref_a[0] = 0; ref_a[1] = 0;
    tick();
  endtask

  task automatic test_load_read();
    logic [7:0] rd; logic rc; int lat;
    do_cmd(0, 2'd0, 8'h3C, 0, 0, rd, rc, lat);
    do_cmd(0, 2'd3, 8'hA5, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h3C || rc !== 1'b0) begin
      n_err++;
      $display("FAIL load_read: got %h c%b expected 3c c0", rd, rc);
    end
  endtask

  task automatic test_add();
    logic [7:0] rd; logic rc; int lat;
    do_cmd(0, 2'd0, 8'hF0, 0, 0, rd, rc, lat);
    do_cmd(0, 2'd1, 8'h20, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h10 || rc !== 1'b1) begin
      n_err++;
      $display("FAIL add_carry: got %h c%b expected 10 c1", rd, rc);
    end
    do_cmd(0, 2'd1, 8'h01, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h11 || rc !== 1'b0) begin
      n_err++;
      $display("FAIL add_nocarry: got %h c%b expected 11 c0", rd, rc);
    end
  endtask

  task automatic test_rol_iter();
    logic [7:0] rd; logic rc; int lat;
    do_cmd(0, 2'd0, 8'h81, 0, 0, rd, rc, lat);
    do_cmd(0, 2'd2, 8'h03, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h0C || lat != 4) begin
      n_err++;
      $display("FAIL rol3: got %h at +%0d expected 0c at +4", rd, lat);
    end
    do_cmd(0, 2'd2, 8'h00, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h0C || lat != 1) begin
      n_err++;
      $display("FAIL rol0: got %h at +%0d expected 0c at +1", rd, lat);
    end
    do_cmd(0, 2'd2, 8'hFD, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h81 || lat != 6) begin
      n_err++;
      $display("FAIL rol5: got %h at +%0d expected 81 at +6", rd, lat);
    end
  endtask

  task automatic test_stall();
    logic [7:0] rd; logic rc; int lat;
    do_cmd(0, 2'd0, 8'h40, 0, 0, rd, rc, lat);
    do_cmd(0, 2'd1, 8'h05, 5, 1, rd, rc, lat);
    do_cmd(0, 2'd3, 8'h00, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h45) begin
      n_err++;
      $display("FAIL stall_a_unchanged: got %h expected 45", rd);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [7:0] rd; logic rc; int lat, guard;
    do_cmd(0, 2'd0, 8'h55, 0, 0, rd, rc, lat);
    guard = 0;
    while (cmd_ready[0] !== 1'b1 && guard < 50) begin tick(); guard++; end
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'd2; cmd_data[0] = 8'h07;
    tick();
    cmd_valid[0] = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_exec: got busy=%b vld=%b expected 1 0", busy[0], rsp_valid[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "async_reset");
    check_reset_outputs(1, "async_reset");
    tick(); tick();
    rst_n = 1'b1;
    ref_a[0] = 0; ref_a[1] = 0;
    do_cmd(0, 2'd3, 8'h00, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h00) begin
      n_err++;
      $display("FAIL read_after_reset: got %h expected 00", rd);
    end
  endtask

  task automatic test_barrel();
    logic [7:0] rd; logic rc; int lat;
    do_cmd(1, 2'd0, 8'h81, 0, 0, rd, rc, lat);
    do_cmd(1, 2'd2, 8'h03, 0, 0, rd, rc, lat);
    n_cmp++;
    if (rd !== 8'h0C || lat != 1) begin
      n_err++;
      $display("FAIL barrel_rol3: got %h at +%0d expected 0c at +1", rd, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd; logic rc; int lat;
    for (int n = 0; n < 1000; n++) begin
      do_cmd(int'($urandom_range(1, 0)), 2'($urandom), 8'($urandom),
             int'($urandom_range(2, 0)), 1'b0, rd, rc, lat);
    end
  endtask

  initial begin
    cmd_valid = '0; rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      cmd_op[d] = 2'd0; cmd_data[d] = 8'h00; ref_a[d] = 0;
    end
    test_reset();
    test_load_read();
    test_add();
    test_rol_iter();
    test_stall();
    test_reset_mid_exec();
    test_barrel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
